// File: rtl/ysyx_22041211_axi_lsu_master.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22041211_axi_lsu_master
// Purpose  : AXI-lite master turning single-beat LSU loads/stores into AR/R or
//            AW/W/B transactions with a one-cycle response pulse.
//            Optional perf counters: define YSYX_22041211_AXI_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22041211_axi_lsu_master #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_wen_i,
    input  logic [ADDR_LEN-1:0]     req_addr_i,
    input  logic [DATA_LEN-1:0]     req_wdata_i,
    input  logic [DATA_LEN/8-1:0]   req_wstrb_i,
    output logic                    rsp_valid_o,
    output logic [DATA_LEN-1:0]     rsp_rdata_o,
    output logic [1:0]              rsp_err_o,
    output logic [ADDR_LEN-1:0]     addr_r_addr_o,
    output logic                    addr_r_valid_o,
    input  logic                    addr_r_ready_i,
    input  logic [DATA_LEN-1:0]     r_data_i,
    input  logic [1:0]              r_resp_i,
    input  logic                    r_valid_i,
    output logic                    r_ready_o,
    output logic [ADDR_LEN-1:0]     addr_w_addr_o,
    output logic                    addr_w_valid_o,
    input  logic                    addr_w_ready_i,
    output logic [DATA_LEN-1:0]     w_data_o,
    output logic [DATA_LEN/8-1:0]   w_strb_o,
    output logic                    w_valid_o,
    input  logic                    w_ready_i,
    input  logic [1:0]              bkwd_resp_i,
    input  logic                    bkwd_valid_i,
    output logic                    bkwd_ready_o,
    output logic [31:0]             perf_rd_cnt_o,
    output logic [31:0]             perf_wr_cnt_o,
    output logic [31:0]             perf_wait_cnt_o
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_RD_ADDR = 3'd1;
    localparam logic [2:0] c_RD_DATA = 3'd2;
    localparam logic [2:0] c_WR_REQ  = 3'd3;
    localparam logic [2:0] c_WR_RESP = 3'd4;

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic                  r_aw_done;
    logic                  r_w_done;
    logic [ADDR_LEN-1:0]   r_addr;
    logic [DATA_LEN-1:0]   r_wdata;
    logic [DATA_LEN/8-1:0] r_wstrb;
    logic                  r_rsp_valid;
    logic [DATA_LEN-1:0]   r_rsp_rdata;
    logic [1:0]            r_rsp_err;

    logic w_req_hs, w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs, w_wr_done;

    assign w_req_hs  = req_valid_i & req_ready_o;
    assign w_ar_hs   = addr_r_valid_o & addr_r_ready_i;
    assign w_r_hs    = r_valid_i & r_ready_o;
    assign w_aw_hs   = addr_w_valid_o & addr_w_ready_i;
    assign w_w_hs    = w_valid_o & w_ready_i;
    assign w_b_hs    = bkwd_valid_i & bkwd_ready_o;
    // Both write channels finished, whether earlier or in this very cycle
    assign w_wr_done = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);

    always_ff @(posedge clk) begin
        if (!rstn) r_state <= c_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:    if (w_req_hs)  w_state_nxt = req_wen_i ? c_WR_REQ : c_RD_ADDR;
            c_RD_ADDR: if (w_ar_hs)   w_state_nxt = c_RD_DATA;
            c_RD_DATA: if (w_r_hs)    w_state_nxt = c_IDLE;
            c_WR_REQ:  if (w_wr_done) w_state_nxt = c_WR_RESP;
            c_WR_RESP: if (w_b_hs)    w_state_nxt = c_IDLE;
            default:                  w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o    = (r_state == c_IDLE) & rstn;
        addr_r_valid_o = (r_state == c_RD_ADDR);
        r_ready_o      = (r_state == c_RD_DATA);
        addr_w_valid_o = (r_state == c_WR_REQ) & ~r_aw_done;
        w_valid_o      = (r_state == c_WR_REQ) & ~r_w_done;
        bkwd_ready_o   = (r_state == c_WR_RESP);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 2'b00;
        end else begin
            if (w_req_hs) begin
                r_addr  <= req_addr_i;
                r_wdata <= req_wdata_i;
                r_wstrb <= req_wstrb_i;
            end
            // Flags live only inside WR_REQ and clear on the way out
            r_aw_done   <= (r_state == c_WR_REQ) & ~w_wr_done & (r_aw_done | w_aw_hs);
            r_w_done    <= (r_state == c_WR_REQ) & ~w_wr_done & (r_w_done | w_w_hs);
            r_rsp_valid <= w_r_hs | w_b_hs;
            if (w_r_hs) begin
                r_rsp_rdata <= r_data_i;
                r_rsp_err   <= r_resp_i;
            end
            if (w_b_hs) r_rsp_err <= bkwd_resp_i;
        end
    end

    assign addr_r_addr_o = r_addr;
    assign addr_w_addr_o = r_addr;
    assign w_data_o      = r_wdata;
    assign w_strb_o      = r_wstrb;
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_rdata_o   = r_rsp_rdata;
    assign rsp_err_o     = r_rsp_err;

`ifdef YSYX_22041211_AXI_PERF_EN
    logic [31:0] r_perf_rd;
    logic [31:0] r_perf_wr;
    logic [31:0] r_perf_wait;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_perf_rd   <= 32'd0;
            r_perf_wr   <= 32'd0;
            r_perf_wait <= 32'd0;
        end else begin
            if (w_r_hs)             r_perf_rd   <= r_perf_rd + 32'd1;
            if (w_b_hs)             r_perf_wr   <= r_perf_wr + 32'd1;
            if (r_state != c_IDLE)  r_perf_wait <= r_perf_wait + 32'd1;
        end
    end

    assign perf_rd_cnt_o   = r_perf_rd;
    assign perf_wr_cnt_o   = r_perf_wr;
    assign perf_wait_cnt_o = r_perf_wait;
`else
    assign perf_rd_cnt_o   = 32'd0;
    assign perf_wr_cnt_o   = 32'd0;
    assign perf_wait_cnt_o = 32'd0;
`endif

endmodule
`default_nettype wire

// File: doc/ysyx_22041211_axi_lsu_master.md
# ysyx_22041211_axi_lsu_master

AXI-lite master that converts single-beat load/store requests from the core's LSU into AXI-lite read (AR/R) or write (AW/W/B) transactions and returns a one-cycle response pulse. It sits between the LSU and the AXI-lite SRAM slave (or the crossbar in front of it). It allows one outstanding transaction. Write address and write data are presented in the same cycle.

## Interface
- ADDR_LEN, 32, address width
- DATA_LEN, 32, data width (strobe is DATA_LEN/8 = 4 bits)
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- req_valid_i / req_ready_o  in/out  1  LSU request handshake
- req_wen_i  in  1  1 = store, 0 = load
- req_addr_i  in  ADDR_LEN  request address
- req_wdata_i  in  DATA_LEN  store data
- req_wstrb_i  in  4  store byte strobe
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_rdata_o  out  DATA_LEN  load data, raw, no extension
- rsp_err_o  out  2  captured RRESP/BRESP
- addr_r_addr_o, addr_r_valid_o / addr_r_ready_i  out,out/in  ADDR_LEN,1/1  AR channel
- r_data_i, r_resp_i, r_valid_i / r_ready_o  in  DATA_LEN,2,1/1  R channel
- addr_w_addr_o, addr_w_valid_o / addr_w_ready_i  out,out/in  ADDR_LEN,1/1  AW channel
- w_data_o, w_strb_o, w_valid_o / w_ready_i  out  DATA_LEN,4,1/1  W channel
- bkwd_resp_i, bkwd_valid_i / bkwd_ready_o  in  2,1/1  B channel
- perf_rd_cnt_o, perf_wr_cnt_o, perf_wait_cnt_o  out  32 each  performance counters

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- req_ready_o = (state==IDLE) & rstn.
- On a request handshake, latch addr, wdata, wstrb and wen. Go to WR_REQ if wen is 1, else RD_ADDR.
- RD_ADDR:
  - addr_r_valid_o=1, driving the latched address.
  - On AR handshake, go to RD_DATA.
- RD_DATA:
  - r_ready_o=1.
  - On R handshake, capture r_data_i into rsp_rdata_o and r_resp_i into rsp_err_o, then go to IDLE.
- WR_REQ:
  - addr_w_valid_o and w_valid_o both rise in the same cycle.
  - Each channel drops independently after its own handshake, tracked by flags aw_done and w_done.
  - When both handshakes have completed (same cycle or different cycles), go to WR_RESP.
- WR_RESP:
  - bkwd_ready_o=1.
  - On B handshake, capture bkwd_resp_i into rsp_err_o and go to IDLE.
  - rsp_rdata_o is unchanged by writes.
- rsp_valid_o is registered: high for exactly one cycle following the R or B handshake. That cycle coincides with the first IDLE cycle.
- Any nonzero resp is reported verbatim. The master does not retry.
- Latched request fields are stable while any valid is high. Unused channel valids are 0.
- Reset, including mid-transaction:
  - State returns to IDLE and the aw_done/w_done flags clear.
  - All AXI valid/ready outputs, rsp_valid_o, rsp_rdata_o and rsp_err_o go to 0.
  - Address and data outputs go to 0.
  - Any in-flight transaction is abandoned and no response is produced.

## Timing
- Cycle 0 is the request handshake.
- Read: AR valid from cycle 1. With a zero-wait slave, R completes in cycle 2 and rsp_valid_o is high in cycle 3. Each slave wait cycle adds one.
- Write: AW and W valid from cycle 1. B completes earliest in cycle 2 and rsp_valid_o is high earliest in cycle 3.
- A new request can be accepted in the same cycle rsp_valid_o is high.
- Nothing is combinational from an AXI input to an AXI output.

## Configuration
- Macro: YSYX_22041211_AXI_PERF_EN.
- Defined:
  - perf_rd_cnt_o increments on each R handshake.
  - perf_wr_cnt_o increments on each B handshake.
  - perf_wait_cnt_o increments every cycle the state is not IDLE.
  - All three reset to 0 and wrap from 0xFFFFFFFF to 0.
- Undefined: the counters are not built and the three ports are tied to 0.

## Test plan
- Load: req addr 0x8000_0010, zero-wait slave returning 0xDEADBEEF with resp 00 -> AR address 0x8000_0010 in cycle 1; rsp_valid_o in cycle 3 with rsp_rdata_o=0xDEADBEEF and rsp_err_o=0.
- Store: addr 0x8000_0020, data 0x1234_5678, strb 4'b0011; slave accepts AW in cycle 1 but holds w_ready_i low until cycle 3 -> addr_w_valid_o drops after cycle 1; w_valid_o held through cycle 3; B accepted no earlier than cycle 4; rsp_valid_o one cycle after B.
- Slow read: R arrives 5 cycles after AR with resp 2'b10 -> r_ready_o held the whole time; rsp_err_o=2'b10; exactly one rsp_valid_o pulse.
- Back-to-back: a second req_valid_i held high during a load -> req_ready_o=0 until the rsp_valid_o cycle; second request accepted in that cycle.
- Reset mid-write: rstn low during WR_RESP -> next cycle all valids/readies are 0, state is IDLE, no rsp_valid_o pulse; a following read completes normally.
- With YSYX_22041211_AXI_PERF_EN: 2 loads + 1 store, all zero-wait -> rd=2, wr=1, wait=6.
